// File: rtl/rvfi_chk_pkg.sv
// Shared types for the RVFI commit checker.
// Checker states and first-error cause codes.
package rvfi_chk_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    ERROR  = 2'd1,
    HALTED = 2'd2
  } chk_state_t;

  typedef enum logic [3:0] {
    NONE    = 4'd0,
    ORDER   = 4'd1,
    PC      = 4'd2,
    RS1     = 4'd3,
    RS2     = 4'd4,
    X0      = 4'd5,
    ALIGN   = 4'd6,
    MASK    = 4'd7,
    TIMEOUT = 4'd8
  } err_code_t;

endpackage

// File: rtl/rvfi_shadow_regfile.sv
// Shadow architectural register file.
// Two async read ports, one sync write port, x0 fixed at zero.
module rvfi_shadow_regfile (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  output logic [31:0] rdata1_o,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata2_o
);

  logic [31:0] regs_q [32];

  // Clear on reset; retire writes except to x0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/rvfi_commit_checker.sv
// RVFI retirement-stream checker.
// Tracks order, PC and a shadow regfile; latches the first error.
module rvfi_commit_checker
  import rvfi_chk_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h6000_0000,
  parameter int unsigned MAX_IDLE = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rvfi_valid,
  input  logic [63:0] rvfi_order,
  input  logic [31:0] rvfi_inst,
  input  logic [4:0]  rvfi_rs1_addr,
  input  logic [4:0]  rvfi_rs2_addr,
  input  logic [31:0] rvfi_rs1_rdata,
  input  logic [31:0] rvfi_rs2_rdata,
  input  logic [4:0]  rvfi_rd_addr,
  input  logic [31:0] rvfi_rd_wdata,
  input  logic [31:0] rvfi_pc_rdata,
  input  logic [31:0] rvfi_pc_wdata,
  input  logic [3:0]  rvfi_dmem_rmask,
  input  logic [3:0]  rvfi_dmem_wmask,
  output logic        err,
  output logic [3:0]  err_code,
  output logic [63:0] err_order,
  output logic [63:0] commit_count,
  output logic        halted
);

  localparam logic [31:0] IDLE_LAST = MAX_IDLE - 1;

  chk_state_t  state_q, state_d;
  err_code_t   code_q, code_d, chk;
  logic [63:0] eorder_q, eorder_d;
  logic [63:0] order_q, order_d;
  logic [63:0] count_q, count_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] idle_q, idle_d;
  logic [31:0] sh_rs1, sh_rs2;
  logic        clean;
  logic        unused_inst;

  assign unused_inst = ^rvfi_inst;

  rvfi_shadow_regfile u_shadow (
    .clk_i    (clk),
    .rst_i    (rst),
    .we_i     (clean),
    .waddr_i  (rvfi_rd_addr),
    .wdata_i  (rvfi_rd_wdata),
    .raddr1_i (rvfi_rs1_addr),
    .rdata1_o (sh_rs1),
    .raddr2_i (rvfi_rs2_addr),
    .rdata2_o (sh_rs2)
  );

  // Prioritised check of the current commit, or idle timeout.
  always_comb begin
    chk = NONE;
    if (state_q == RUN) begin
      if (rvfi_valid) begin
        if (rvfi_order != order_q)
          chk = ORDER;
        else if (rvfi_pc_rdata != pc_q)
          chk = PC;
        else if (rvfi_rs1_rdata != sh_rs1)
          chk = RS1;
        else if (rvfi_rs2_rdata != sh_rs2)
          chk = RS2;
        else if (rvfi_rd_addr == 5'd0 &&
                 rvfi_rd_wdata != 32'd0)
          chk = X0;
        else if (rvfi_pc_wdata[1:0] != 2'b00)
          chk = ALIGN;
        else if (rvfi_dmem_rmask != 4'd0 &&
                 rvfi_dmem_wmask != 4'd0)
          chk = MASK;
      end else if (idle_q == IDLE_LAST) begin
        chk = TIMEOUT;
      end
    end
  end

  assign clean = (state_q == RUN) && rvfi_valid &&
                 (chk == NONE);

  // Next-state: record first error or apply a clean commit.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    eorder_d = eorder_q;
    order_d  = order_q;
    count_d  = count_q;
    pc_d     = pc_q;
    idle_d   = idle_q;
    if (chk != NONE) begin
      state_d  = ERROR;
      code_d   = chk;
      eorder_d = (chk == TIMEOUT) ? '0 : rvfi_order;
    end else if (clean) begin
      order_d = order_q + 64'd1;
      count_d = count_q + 64'd1;
      pc_d    = rvfi_pc_wdata;
      if (rvfi_pc_wdata == rvfi_pc_rdata)
        state_d = HALTED;
    end
    if (state_q == RUN) begin
      if (rvfi_valid)
        idle_d = '0;
      else if (idle_q != '1)
        idle_d = idle_q + 32'd1;
    end
  end

  // Checker state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      code_q   <= NONE;
      eorder_q <= '0;
      order_q  <= '0;
      count_q  <= '0;
      pc_q     <= RESET_PC;
      idle_q   <= '0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      eorder_q <= eorder_d;
      order_q  <= order_d;
      count_q  <= count_d;
      pc_q     <= pc_d;
      idle_q   <= idle_d;
    end
  end

  assign err          = (state_q == ERROR);
  assign halted       = (state_q == HALTED);
  assign err_code     = code_q;
  assign err_order    = eorder_q;
  assign commit_count = count_q;

endmodule

// File: tb/tb_rvfi_commit_checker.sv
// Bench for rvfi_commit_checker.
// Expected outputs are queued at drive time and popped after the edge.
module tb_rvfi_commit_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [63:0] order;
  logic [31:0] inst;
  logic [4:0]  rs1a, rs2a, rda;
  logic [31:0] rs1d, rs2d, rdw;
  logic [31:0] pcr, pcw;
  logic [3:0]  rmask, wmask;
  logic        err;
  logic [3:0]  err_code;
  logic [63:0] err_order;
  logic [63:0] commit_count;
  logic        halted;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic        err;
    logic [3:0]  code;
    logic [63:0] eord;
    logic [63:0] cnt;
    logic        halt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  rvfi_commit_checker #(
    .RESET_PC (32'h6000_0000),
    .MAX_IDLE (1000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rvfi_valid      (valid),
    .rvfi_order      (order),
    .rvfi_inst       (inst),
    .rvfi_rs1_addr   (rs1a),
    .rvfi_rs2_addr   (rs2a),
    .rvfi_rs1_rdata  (rs1d),
    .rvfi_rs2_rdata  (rs2d),
    .rvfi_rd_addr    (rda),
    .rvfi_rd_wdata   (rdw),
    .rvfi_pc_rdata   (pcr),
    .rvfi_pc_wdata   (pcw),
    .rvfi_dmem_rmask (rmask),
    .rvfi_dmem_wmask (wmask),
    .err             (err),
    .err_code        (err_code),
    .err_order       (err_order),
    .commit_count    (commit_count),
    .halted          (halted)
  );

  task automatic check_eq(string tag,
                          logic [63:0] got,
                          logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, want);
    end
  endtask

  task automatic push_exp(logic e, logic [3:0] c,
                          logic [63:0] eo,
                          logic [63:0] cnt, logic h);
    exp_t x;
    x.err  = e;
    x.code = c;
    x.eord = eo;
    x.cnt  = cnt;
    x.halt = h;
    sb.push_back(x);
  endtask

  task automatic pop_cmp(string tag);
    exp_t x;
    check_eq({tag, ".sb"}, 64'(sb.size()), 64'd1);
    if (sb.size() == 0) return;
    x = sb.pop_front();
    check_eq({tag, ".err"}, 64'(err), 64'(x.err));
    check_eq({tag, ".code"}, 64'(err_code), 64'(x.code));
    check_eq({tag, ".eord"}, err_order, x.eord);
    check_eq({tag, ".cnt"}, commit_count, x.cnt);
    check_eq({tag, ".halt"}, 64'(halted), 64'(x.halt));
  endtask

  task automatic reset_dut(string tag);
    @(negedge clk);
    valid = 1'b0;
    rst   = 1'b1;
    push_exp(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    pop_cmp(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(int n);
    valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic commit(logic [63:0] o,
                        logic [31:0] pc, logic [31:0] pn,
                        logic [4:0] r1a, logic [31:0] r1d,
                        logic [4:0] r2a, logic [31:0] r2d,
                        logic [4:0] wa, logic [31:0] wd,
                        logic [3:0] rm, logic [3:0] wm);
    @(negedge clk);
    valid = 1'b1;
    order = o;
    inst  = $urandom;
    pcr   = pc;
    pcw   = pn;
    rs1a  = r1a;
    rs1d  = r1d;
    rs2a  = r2a;
    rs2d  = r2d;
    rda   = wa;
    rdw   = wd;
    rmask = rm;
    wmask = wm;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] B = 32'h6000_0000;

  initial begin
    rst = 1'b1;
    valid = 1'b0;
    order = '0; inst = '0;
    rs1a = '0; rs2a = '0; rda = '0;
    rs1d = '0; rs2d = '0; rdw = '0;
    pcr = '0; pcw = '0; rmask = '0; wmask = '0;

    // clean stream, back-to-back, then self-loop halt
    reset_dut("t1.rst");
    push_exp(0, 0, 0, 1, 0);
    commit(0, B, B+4, 0, 0, 0, 0, 1, 5, 0, 0);
    pop_cmp("t1.c0");
    push_exp(0, 0, 0, 2, 0);
    commit(1, B+4, B+8, 1, 5, 1, 5, 2, 10, 0, 0);
    pop_cmp("t1.c1");
    push_exp(0, 0, 0, 3, 0);
    commit(2, B+8, B+12, 2, 10, 1, 5, 3, 15, 1, 0);
    pop_cmp("t1.c2");
    push_exp(0, 0, 0, 4, 0);
    commit(3, B+12, B+16, 3, 15, 0, 0, 0, 0, 0, 4'hf);
    pop_cmp("t1.c3");
    push_exp(0, 0, 0, 5, 1);
    commit(4, B+16, B+16, 0, 0, 0, 0, 0, 0, 0, 0);
    pop_cmp("t1.halt");
    push_exp(0, 0, 0, 5, 1);
    idle(2000);
    pop_cmp("t1.idle");
    push_exp(0, 0, 0, 5, 1);
    commit(5, B+16, B+20, 0, 0, 0, 0, 0, 0, 0, 0);
    pop_cmp("t1.post");

    // order error, sticky
    reset_dut("t2.rst");
    push_exp(0, 0, 0, 1, 0);
    commit(0, B, B+4, 0, 0, 0, 0, 1, 5, 0, 0);
    pop_cmp("t2.c0");
    push_exp(1, 1, 2, 1, 0);
    commit(2, B+4, B+8, 0, 0, 0, 0, 0, 0, 0, 0);
    pop_cmp("t2.ord");
    push_exp(1, 1, 2, 1, 0);
    commit(1, B+4, B+8, 0, 0, 0, 0, 0, 0, 0, 0);
    pop_cmp("t2.sticky");

    // rs2 mismatch
    reset_dut("t3.rst");
    push_exp(0, 0, 0, 1, 0);
    commit(0, B, B+4, 0, 0, 0, 0, 1, 5, 0, 0);
    pop_cmp("t3.c0");
    push_exp(1, 4, 1, 1, 0);
    commit(1, B+4, B+8, 0, 0, 1, 7, 0, 0, 0, 0);
    pop_cmp("t3.rs2");

    // reset clears shadow; then rs1 mismatch
    reset_dut("t4.rst");
    push_exp(0, 0, 0, 1, 0);
    commit(0, B, B+4, 1, 0, 0, 0, 0, 0, 0, 0);
    pop_cmp("t4.clr");
    push_exp(1, 3, 1, 1, 0);
    commit(1, B+4, B+8, 1, 5, 0, 0, 0, 0, 0, 0);
    pop_cmp("t4.rs1");

    // x0 write, and order taking priority over it
    reset_dut("t5.rst");
    push_exp(1, 5, 0, 0, 0);
    commit(0, B, B+4, 0, 0, 0, 0, 0, 32'h1234, 0, 0);
    pop_cmp("t5.x0");
    reset_dut("t5.rst2");
    push_exp(1, 1, 5, 0, 0);
    commit(5, B, B+4, 0, 0, 0, 0, 0, 32'h1234, 0, 0);
    pop_cmp("t5.prio");

    // pc, align, mask
    reset_dut("t6.rst");
    push_exp(1, 2, 0, 0, 0);
    commit(0, B+4, B+8, 0, 0, 0, 0, 0, 0, 0, 0);
    pop_cmp("t6.pc");
    reset_dut("t7.rst");
    push_exp(1, 6, 0, 0, 0);
    commit(0, B, B+2, 0, 0, 0, 0, 0, 0, 0, 0);
    pop_cmp("t7.align");
    reset_dut("t8.rst");
    push_exp(1, 7, 0, 0, 0);
    commit(0, B, B+4, 0, 0, 0, 0, 0, 0, 1, 2);
    pop_cmp("t8.mask");

    // timeout boundary, then reset back to RUN
    reset_dut("t9.rst");
    push_exp(0, 0, 0, 0, 0);
    idle(999);
    pop_cmp("t9.999");
    push_exp(1, 8, 0, 0, 0);
    idle(1);
    pop_cmp("t9.1000");
    reset_dut("t9.rst2");
    push_exp(0, 0, 0, 1, 0);
    commit(0, B, B+4, 0, 0, 0, 0, 0, 0, 0, 0);
    pop_cmp("t9.run");

    valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rvfi_commit_checker.md
Name: rvfi_commit_checker

Overview:
- Consumer end of the RVFI commit interface driven by the pipeline writeback stage.
- Reconstructs architectural state from the retired-instruction stream: expected order, expected PC, and a shadow register file.
- Flags the first protocol or consistency violation and holds it sticky.
- Detects the self-loop halt and commit-stream hangs.
- Simulation-side block; synthesizable RTL style.

Parameters:
- RESET_PC, 32'h6000_0000, PC expected on the first commit after reset.
- MAX_IDLE, 1000, cycles without a commit (in RUN) before a timeout error is raised.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rvfi_valid  in  1  commit strobe
- rvfi_order  in  64  retirement index
- rvfi_inst  in  32  instruction word
- rvfi_rs1_addr / rvfi_rs2_addr  in  5 each  source register indices
- rvfi_rs1_rdata / rvfi_rs2_rdata  in  32 each  source operand values
- rvfi_rd_addr  in  5  destination register
- rvfi_rd_wdata  in  32  destination value
- rvfi_pc_rdata / rvfi_pc_wdata  in  32 each  current PC / next PC
- rvfi_dmem_rmask / rvfi_dmem_wmask  in  4 each  byte masks
- err  out  1  sticky error flag
- err_code  out  4  first error cause
- err_order  out  64  rvfi_order of the offending commit (0 for timeout)
- commit_count  out  64  commits accepted in RUN
- halted  out  1  self-loop halt reached

Behaviour:
- Reset (synchronous, active-high rst; single clock clk):
  - state=RUN, exp_order=0, exp_pc=RESET_PC.
  - Shadow regfile all zero; idle_cnt=0.
  - All outputs 0.
- States:
  - RUN -> ERROR on any check failure or timeout.
  - RUN -> HALTED on a clean commit with pc_wdata==pc_rdata.
  - ERROR and HALTED are absorbing until rst; rst mid-run returns to RUN with reset values.
- Checks are evaluated combinationally on rvfi_valid in RUN, against state before this commit's update. Priority, lowest code wins:
  - 1 ORDER: rvfi_order != exp_order.
  - 2 PC: pc_rdata != exp_pc.
  - 3 RS1: rs1_rdata != shadow[rs1_addr]; shadow[0] reads as 0.
  - 4 RS2: same check for rs2.
  - 5 X0: rd_addr==0 and rd_wdata!=0.
  - 6 ALIGN: pc_wdata[1:0]!=0.
  - 7 MASK: rmask!=0 and wmask!=0.
  - 8 TIMEOUT: idle_cnt reaches MAX_IDLE.
- Error response:
  - err, err_code and err_order are registered; they appear the cycle after the offending commit.
  - Only the first error is recorded; later commits are ignored.
- Clean commit in RUN:
  - exp_order+=1; exp_pc=pc_wdata; commit_count+=1.
  - shadow[rd_addr]=rd_wdata if rd_addr!=0.
  - All updates are visible to a commit in the very next cycle (back-to-back commits supported, no bubble required).
- Failing commit: no shadow, order, PC or count update.
- idle_cnt:
  - Clears on every valid commit; increments otherwise in RUN; saturates.
  - Frozen in ERROR and HALTED, so no timeout fires after a halt.
- Width rules: order and count are 64-bit with natural wrap (unreachable in practice). PC compares are full 32-bit.
- Inputs are ignored while rvfi_valid=0, including X values; no check depends on rvfi_inst.

Decomposition:
- Package rvfi_chk_pkg: chk_state_t enum (RUN, ERROR, HALTED); err_code_t enum (NONE=0, ORDER=1 … TIMEOUT=8).
- Sub-module rvfi_shadow_regfile: 32x32 storage, two combinational read ports, one synchronous write port, x0 hardwired to 0, synchronous reset to zero.

Test Plan:
- Commits order 0,1,2 with PCs 0x60000000→04→08, addi x1=5 then add x2,x1,x1 with rs1_rdata=5, rd_wdata=10 -> err=0, commit_count=3, shadow x2=10.
- Second commit with order=2 instead of 1 -> next cycle err=1, err_code=1, err_order=2; further commits leave count at 1.
- Commit with rs2_addr=1, rs2_rdata=7 while shadow x1=5 -> err_code=4.
- Commit with rd_addr=0, rd_wdata=0x1234 -> err_code=5. The same commit with order also wrong -> err_code=1 (priority).
- Clean jal x0,0 at 0x60000010 with pc_wdata=pc_rdata -> halted=1; 2000 idle cycles follow -> err stays 0.
- With MAX_IDLE=1000: no commits for 1000 cycles after reset -> err=1, err_code=8. Then assert rst for 1 cycle -> all outputs 0, state RUN.
